// File: rtl/simdive_issue_ctrl.sv
// Issue controller that arbitrates two requesters onto a hybrid SIMD multiplier-divider.
// Define SIMDIVE_PAIRING_EN to pack two narrow requests into one dual-lane issue.
module simdive_issue_ctrl #(
   parameter int N   = 16,
   parameter int lgN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic             b_valid,
   output logic             a_ready,
   output logic             b_ready,
   input  logic             a_wide,
   input  logic             b_wide,
   input  logic             a_div,
   input  logic             b_div,
   input  logic [N-1:0]     a_x,
   input  logic [N-1:0]     a_y,
   input  logic [N-1:0]     b_x,
   input  logic [N-1:0]     b_y,
   output logic             a_rsp_valid,
   output logic             b_rsp_valid,
   input  logic             a_rsp_ready,
   input  logic             b_rsp_ready,
   output logic [2*N-1:0]   a_rsp_data,
   output logic [2*N-1:0]   b_rsp_data,
   output logic [N-1:0]     dp_input1,
   output logic [N-1:0]     dp_input2,
   output logic             dp_mode,
   output logic [2:0]       dp_func,
   input  logic [2*N-1:0]   dp_result
);

   localparam int H = 1 << (lgN - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t           state_r;
   logic             ptr_r;
   logic             pair_r;
   logic             a_iss_r, b_iss_r;
   logic             a_wide_r, b_wide_r;
   logic             a_div_r, b_div_r;
   logic             a_rsp_valid_r, b_rsp_valid_r;
   logic [2*N-1:0]   a_rsp_data_r, b_rsp_data_r;
   logic [N-1:0]     dp_input1_r, dp_input2_r;
   logic             dp_mode_r;
   logic [2:0]       dp_func_r;

   logic             pair_s, grant_a_s, grant_b_s;
   logic             s_wide_s, s_div_s;
   logic [N-1:0]     s_x_s, s_y_s, in1_s, in2_s;
   logic [2:0]       func_s;
   logic             a_zero_s, b_zero_s;
   logic [2*N-1:0]   a_res_s, b_res_s;
   logic             a_left_s, b_left_s;

   // Zero-divisor override, then wide/narrow selection with zero extension.
   function automatic logic [2*N-1:0] lane_result(input logic div, input logic zero, input logic wide,
                                                  input logic [N-1:0] narrow_res, input logic [2*N-1:0] full_res);
      logic [2*N-1:0] r;
      if (div && zero)
         r = wide ? {(2*N){1'b1}} : {{N{1'b0}}, {N{1'b1}}};
      else if (wide)
         r = full_res;
      else
         r = {{N{1'b0}}, narrow_res};
      return r;
   endfunction

   // Issue decision: pairing, round-robin grant and datapath operand packing.
   always_comb begin
`ifdef SIMDIVE_PAIRING_EN
      pair_s = a_valid && b_valid && !a_wide && !b_wide;
`else
      pair_s = 1'b0;
`endif
      grant_a_s = rst_n && (state_r == IDLE) && a_valid && (pair_s || !b_valid || !ptr_r);
      grant_b_s = rst_n && (state_r == IDLE) && b_valid && (pair_s || !a_valid || ptr_r);
      s_wide_s  = grant_a_s ? a_wide : b_wide;
      s_div_s   = grant_a_s ? a_div  : b_div;
      s_x_s     = grant_a_s ? a_x    : b_x;
      s_y_s     = grant_a_s ? a_y    : b_y;
      if (pair_s) begin
         in1_s  = {a_x[H-1:0], b_x[H-1:0]};
         in2_s  = {a_y[H-1:0], b_y[H-1:0]};
         func_s = (a_div && b_div) ? 3'b111 : {1'b0, a_div, b_div};
      end else begin
         in1_s  = s_wide_s ? s_x_s : {{(N-H){1'b0}}, s_x_s[H-1:0]};
         in2_s  = s_wide_s ? s_y_s : {{(N-H){1'b0}}, s_y_s[H-1:0]};
         func_s = {s_div_s, 2'b00};
      end
   end

   // Response formation from the datapath result and outstanding-response tracking.
   always_comb begin
      a_zero_s = pair_r ? (dp_input2_r[N-1:H] == {(N-H){1'b0}}) : (dp_input2_r == {N{1'b0}});
      b_zero_s = pair_r ? (dp_input2_r[H-1:0] == {H{1'b0}})     : (dp_input2_r == {N{1'b0}});
      a_res_s  = lane_result(a_div_r, a_zero_s, a_wide_r,
                             pair_r ? dp_result[2*N-1:N] : dp_result[N-1:0], dp_result);
      b_res_s  = lane_result(b_div_r, b_zero_s, b_wide_r, dp_result[N-1:0], dp_result);
      a_left_s = a_rsp_valid_r && !a_rsp_ready;
      b_left_s = b_rsp_valid_r && !b_rsp_ready;
   end

   // Transaction FSM with registered datapath operands and responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         ptr_r         <= 1'b0;
         pair_r        <= 1'b0;
         a_iss_r       <= 1'b0;
         b_iss_r       <= 1'b0;
         a_wide_r      <= 1'b0;
         b_wide_r      <= 1'b0;
         a_div_r       <= 1'b0;
         b_div_r       <= 1'b0;
         a_rsp_valid_r <= 1'b0;
         b_rsp_valid_r <= 1'b0;
         a_rsp_data_r  <= {(2*N){1'b0}};
         b_rsp_data_r  <= {(2*N){1'b0}};
         dp_input1_r   <= {N{1'b0}};
         dp_input2_r   <= {N{1'b0}};
         dp_mode_r     <= 1'b0;
         dp_func_r     <= 3'b000;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_a_s || grant_b_s) begin
                  state_r     <= EXEC;
                  a_iss_r     <= grant_a_s;
                  b_iss_r     <= grant_b_s;
                  pair_r      <= pair_s;
                  a_wide_r    <= a_wide;
                  b_wide_r    <= b_wide;
                  a_div_r     <= a_div;
                  b_div_r     <= b_div;
                  dp_input1_r <= in1_s;
                  dp_input2_r <= in2_s;
                  dp_mode_r   <= pair_s;
                  dp_func_r   <= func_s;
                  if (!pair_s)
                     ptr_r <= ~ptr_r;
               end
            end
            EXEC: begin
               state_r       <= RESP;
               a_rsp_valid_r <= a_iss_r;
               b_rsp_valid_r <= b_iss_r;
               if (a_iss_r)
                  a_rsp_data_r <= a_res_s;
               if (b_iss_r)
                  b_rsp_data_r <= b_res_s;
            end
            RESP: begin
               a_rsp_valid_r <= a_left_s;
               b_rsp_valid_r <= b_left_s;
               if (!a_left_s && !b_left_s)
                  state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign a_ready     = grant_a_s;
   assign b_ready     = grant_b_s;
   assign a_rsp_valid = a_rsp_valid_r;
   assign b_rsp_valid = b_rsp_valid_r;
   assign a_rsp_data  = a_rsp_data_r;
   assign b_rsp_data  = b_rsp_data_r;
   assign dp_input1   = dp_input1_r;
   assign dp_input2   = dp_input2_r;
   assign dp_mode     = dp_mode_r;
   assign dp_func     = dp_func_r;

endmodule

// File: tb/tb_simdive_issue_ctrl.sv
// Directed self-checking bench for simdive_issue_ctrl (N=16); expectations follow SIMDIVE_PAIRING_EN.
module tb_simdive_issue_ctrl;

   logic          clk;
   logic          rst_n;
   logic          a_valid, b_valid, a_ready, b_ready;
   logic          a_wide, b_wide, a_div, b_div;
   logic [15:0]   a_x, a_y, b_x, b_y;
   logic          a_rsp_valid, b_rsp_valid, a_rsp_ready, b_rsp_ready;
   logic [31:0]   a_rsp_data, b_rsp_data;
   logic [15:0]   dp_input1, dp_input2;
   logic          dp_mode;
   logic [2:0]    dp_func;
   logic [31:0]   dp_result;
   logic [31:0]   dpr;

   int            n_checks;
   int            n_fails;
   logic [31:0]   exp_a;
   logic          exp_mode;

   assign dp_result = dpr;

   simdive_issue_ctrl #(.N(16), .lgN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
      .a_wide(a_wide), .b_wide(b_wide), .a_div(a_div), .b_div(b_div),
      .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y),
      .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
      .a_rsp_ready(a_rsp_ready), .b_rsp_ready(b_rsp_ready),
      .a_rsp_data(a_rsp_data), .b_rsp_data(b_rsp_data),
      .dp_input1(dp_input1), .dp_input2(dp_input2),
      .dp_mode(dp_mode), .dp_func(dp_func), .dp_result(dp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0; n_fails = 0;
      rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
      a_wide = 1'b0; b_wide = 1'b0; a_div = 1'b0; b_div = 1'b0;
      a_x = 16'h0000; a_y = 16'h0000; b_x = 16'h0000; b_y = 16'h0000;
      a_rsp_ready = 1'b1; b_rsp_ready = 1'b1; dpr = 32'h0000_0000;
      #3;
      check_val("rst_a_ready", a_ready, 64'd0);
      check_val("rst_b_ready", b_ready, 64'd0);
      check_val("rst_a_rsp_valid", a_rsp_valid, 64'd0);
      check_val("rst_b_rsp_valid", b_rsp_valid, 64'd0);
      check_val("rst_dp_input1", dp_input1, 64'd0);
      check_val("rst_dp_func", dp_func, 64'd0);
      check_val("rst_a_rsp_data", a_rsp_data, 64'd0);
      a_valid = 1'b0; b_valid = 1'b0;
      step(); rst_n = 1'b1;

      // Single narrow multiply on A
      step(); a_valid = 1'b1; a_x = 16'h000B; a_y = 16'h0033; dpr = 32'hDEAD_0231; #1;
      check_val("t1_a_ready", a_ready, 64'd1);
      check_val("t1_b_ready", b_ready, 64'd0);
      step(); a_valid = 1'b0; #1;
      check_val("t1_mode", dp_mode, 64'd0);
      check_val("t1_func", dp_func, 64'd0);
      check_val("t1_in1", dp_input1, 64'h000B);
      check_val("t1_in2", dp_input2, 64'h0033);
      check_val("t1_no_rsp_yet", a_rsp_valid, 64'd0);
      step(); #1;
      check_val("t1_rsp_valid", a_rsp_valid, 64'd1);
      check_val("t1_rsp_data", a_rsp_data, 64'h0000_0231);
      check_val("t1_b_rsp_valid", b_rsp_valid, 64'd0);
      step(); #1;
      check_val("t1_rsp_done", a_rsp_valid, 64'd0);

      // Both narrow: A mul, B div (paired, or two single issues with B first)
      step(); a_valid = 1'b1; b_valid = 1'b1; a_x = 16'h0033; a_y = 16'h000B; a_div = 1'b0;
      b_x = 16'h0033; b_y = 16'h000B; b_div = 1'b1; dpr = 32'h0231_0004; #1;
`ifdef SIMDIVE_PAIRING_EN
      check_val("t2_a_ready", a_ready, 64'd1);
      check_val("t2_b_ready", b_ready, 64'd1);
      step(); a_valid = 1'b0; b_valid = 1'b0; #1;
      check_val("t2_mode", dp_mode, 64'd1);
      check_val("t2_in1", dp_input1, 64'h3333);
      check_val("t2_in2", dp_input2, 64'h0B0B);
      check_val("t2_func", dp_func, 64'd1);
      step(); #1;
      check_val("t2_a_rsp_valid", a_rsp_valid, 64'd1);
      check_val("t2_a_rsp_data", a_rsp_data, 64'h0000_0231);
      check_val("t2_b_rsp_valid", b_rsp_valid, 64'd1);
      check_val("t2_b_rsp_data", b_rsp_data, 64'h0000_0004);
      step(); #1;
      check_val("t2_a_done", a_rsp_valid, 64'd0);
      check_val("t2_b_done", b_rsp_valid, 64'd0);
`else
      check_val("t2_a_ready", a_ready, 64'd0);
      check_val("t2_b_ready", b_ready, 64'd1);
      step(); b_valid = 1'b0; #1;
      check_val("t2_b_mode", dp_mode, 64'd0);
      check_val("t2_b_func", dp_func, 64'd4);
      check_val("t2_b_in1", dp_input1, 64'h0033);
      check_val("t2_b_in2", dp_input2, 64'h000B);
      check_val("t2_a_wait_exec", a_ready, 64'd0);
      step(); #1;
      check_val("t2_b_rsp_valid", b_rsp_valid, 64'd1);
      check_val("t2_b_rsp_data", b_rsp_data, 64'h0000_0004);
      check_val("t2_a_no_rsp", a_rsp_valid, 64'd0);
      check_val("t2_a_wait_resp", a_ready, 64'd0);
      step(); dpr = 32'h0000_0231; #1;
      check_val("t2_a_ready", a_ready, 64'd1);
      step(); a_valid = 1'b0; #1;
      check_val("t2_a_mode", dp_mode, 64'd0);
      check_val("t2_a_func", dp_func, 64'd0);
      check_val("t2_a_in1", dp_input1, 64'h0033);
      step(); #1;
      check_val("t2_a_rsp_valid", a_rsp_valid, 64'd1);
      check_val("t2_a_rsp_data", a_rsp_data, 64'h0000_0231);
      step(); #1;
      check_val("t2_a_done", a_rsp_valid, 64'd0);
`endif

      // Divide by zero: B narrow, then A wide
      step(); b_valid = 1'b1; b_wide = 1'b0; b_div = 1'b1; b_x = 16'h0055; b_y = 16'h0000;
      dpr = 32'h1234_5678; #1;
      check_val("t4_b_ready", b_ready, 64'd1);
      step(); b_valid = 1'b0; #1;
      check_val("t4_b_func", dp_func, 64'd4);
      check_val("t4_b_in2", dp_input2, 64'h0000);
      step(); #1;
      check_val("t4_b_rsp_valid", b_rsp_valid, 64'd1);
      check_val("t4_b_rsp_data", b_rsp_data, 64'h0000_FFFF);
      step(); a_valid = 1'b1; a_wide = 1'b1; a_div = 1'b1; a_x = 16'hABCD; a_y = 16'h0000; #1;
      check_val("t4_b_done", b_rsp_valid, 64'd0);
      check_val("t4_a_ready", a_ready, 64'd1);
      step(); a_valid = 1'b0; #1;
      check_val("t4_a_in1", dp_input1, 64'hABCD);
      check_val("t4_a_func", dp_func, 64'd4);
      step(); #1;
      check_val("t4_a_rsp_data", a_rsp_data, 64'hFFFF_FFFF);
      step(); #1;
      check_val("t4_a_done", a_rsp_valid, 64'd0);

      // Asynchronous reset during EXEC discards the transaction
      step(); a_valid = 1'b1; a_wide = 1'b1; a_div = 1'b1; a_x = 16'h1234; a_y = 16'h5678; #1;
      check_val("t6_a_ready", a_ready, 64'd1);
      step(); a_valid = 1'b0; #1;
      check_val("t6_func_exec", dp_func, 64'd4);
      #2; rst_n = 1'b0; #1;
      check_val("t6_in1", dp_input1, 64'd0);
      check_val("t6_in2", dp_input2, 64'd0);
      check_val("t6_func", dp_func, 64'd0);
      check_val("t6_mode", dp_mode, 64'd0);
      step(); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         check_val("t6_no_a_rsp", a_rsp_valid, 64'd0);
         check_val("t6_no_b_rsp", b_rsp_valid, 64'd0);
      end

      // Round-robin: A wide vs B narrow, both held
      step(); a_valid = 1'b1; a_wide = 1'b1; a_div = 1'b0; a_x = 16'h1234; a_y = 16'h0100;
      b_valid = 1'b1; b_wide = 1'b0; b_div = 1'b0; b_x = 16'h0002; b_y = 16'h0003;
      dpr = 32'h0012_3400; #1;
      check_val("t3_c0_a_ready", a_ready, 64'd1);
      check_val("t3_c0_b_ready", b_ready, 64'd0);
      step(); #1;
      check_val("t3_a_in1", dp_input1, 64'h1234);
      check_val("t3_a_in2", dp_input2, 64'h0100);
      check_val("t3_b_wait", b_ready, 64'd0);
      step(); #1;
      check_val("t3_a_rsp_data", a_rsp_data, 64'h0012_3400);
      step(); dpr = 32'hFFFF_0006; #1;
      check_val("t3_c3_b_ready", b_ready, 64'd1);
      check_val("t3_c3_a_ready", a_ready, 64'd0);
      step(); #1;
      check_val("t3_b_in1", dp_input1, 64'h0002);
      check_val("t3_b_in2", dp_input2, 64'h0003);
      check_val("t3_b_mode", dp_mode, 64'd0);
      step(); #1;
      check_val("t3_b_rsp_valid", b_rsp_valid, 64'd1);
      check_val("t3_b_rsp_data", b_rsp_data, 64'h0000_0006);
      step(); dpr = 32'h0000_0001; #1;
      check_val("t3_c6_a_ready", a_ready, 64'd1);
      check_val("t3_c6_b_ready", b_ready, 64'd0);
      step(); a_valid = 1'b0; b_valid = 1'b0;
      step(); #1;
      check_val("t3_a2_rsp_data", a_rsp_data, 64'h0000_0001);
      step(); #1;
      check_val("t3_a2_done", a_rsp_valid, 64'd0);

      // A response back-pressured for 5 cycles
`ifdef SIMDIVE_PAIRING_EN
      exp_a = 32'h0000_003F; exp_mode = 1'b1;
`else
      exp_a = 32'h0000_0008; exp_mode = 1'b0;
`endif
      step(); a_valid = 1'b1; a_wide = 1'b0; a_div = 1'b0; a_x = 16'h0007; a_y = 16'h0009;
`ifdef SIMDIVE_PAIRING_EN
      b_valid = 1'b1; b_wide = 1'b0; b_div = 1'b1; b_x = 16'h0010; b_y = 16'h0002;
`endif
      a_rsp_ready = 1'b0; b_rsp_ready = 1'b1; dpr = 32'h003F_0008; #1;
      check_val("t5_a_ready", a_ready, 64'd1);
      step(); a_valid = 1'b0; b_valid = 1'b0; #1;
      check_val("t5_mode", dp_mode, {63'd0, exp_mode});
      step(); #1;
      check_val("t5_a_rsp_valid", a_rsp_valid, 64'd1);
      check_val("t5_a_rsp_data", a_rsp_data, {32'd0, exp_a});
`ifdef SIMDIVE_PAIRING_EN
      check_val("t5_b_rsp_valid", b_rsp_valid, 64'd1);
      check_val("t5_b_rsp_data", b_rsp_data, 64'h0000_0008);
`endif
      for (int i = 0; i < 4; i++) begin
         step(); a_valid = 1'b1; a_x = 16'h0002; a_y = 16'h0002; #1;
         check_val("t5_hold_valid", a_rsp_valid, 64'd1);
         check_val("t5_hold_data", a_rsp_data, {32'd0, exp_a});
         check_val("t5_b_idle", b_rsp_valid, 64'd0);
         check_val("t5_no_accept", a_ready, 64'd0);
      end
      step(); a_rsp_ready = 1'b1; #1;
      check_val("t5_last_hold", a_rsp_valid, 64'd1);
      step(); dpr = 32'h0000_0004; #1;
      check_val("t5_consumed", a_rsp_valid, 64'd0);
      check_val("t5_idle_accept", a_ready, 64'd1);
      step(); a_valid = 1'b0;
      step(); #1;
      check_val("t5_next_rsp", a_rsp_data, 64'h0000_0004);
      step(); #1;
      check_val("t5_next_done", a_rsp_valid, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/simdive_issue_ctrl.md
SIMDIVE_ISSUE_CTRL -- requirements
Module: simdive_issue_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, meaning the full operand width; each SIMD lane is N/2 bits.
REQ-002 SHALL have parameter lgN, default 4, meaning log2(N).
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 a_valid, b_valid  in  1 each  requester A/B holds a request.
REQ-007 a_ready, b_ready  out  1 each  request accepted this cycle when high with the matching valid.
REQ-008 a_wide, b_wide  in  1 each  1 = N-bit op, 0 = N/2-bit op on bits [N/2-1:0].
REQ-009 a_div, b_div  in  1 each  1 = divide x/y, 0 = multiply x*y.
REQ-010 a_x, a_y, b_x, b_y  in  N each  operands.
REQ-011 a_rsp_valid, b_rsp_valid  out  1 each  response available.
REQ-012 a_rsp_ready, b_rsp_ready  in  1 each  requester consumes the response.
REQ-013 a_rsp_data, b_rsp_data  out  2N each  result, zero-extended.
REQ-014 dp_input1, dp_input2  out  N each  registered operands to the hybrid multiplier-divider.
REQ-015 dp_mode  out  1  0 = single N-bit op, 1 = dual N/2-bit SIMD.
REQ-016 dp_func  out  3  datapath function code.
REQ-017 dp_result  in  2N  combinational datapath result.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and RESP.
REQ-019 In IDLE with any valid, SHALL accept requests, load the dp_* registers, assert the matching ready(s) for exactly that cycle, and go to EXEC.
REQ-020 Pairing SHALL occur when a_valid and b_valid are high and both are narrow: dp_mode=1, dp_input1={a_x[N/2-1:0],b_x[N/2-1:0]}, dp_input2={a_y[N/2-1:0],b_y[N/2-1:0]}.
REQ-021 Paired dp_func SHALL be 3'b111 if a_div and b_div are both set, else {1'b0,a_div,b_div}; A is the upper lane.
REQ-022 A single issue SHALL drive dp_mode=0 and dp_func={div,2'b00}; narrow operands are zero-extended to N bits.
REQ-023 When both requesters are valid and cannot be paired, the grant SHALL go to the round-robin pointer (reset = A); the pointer toggles after every single grant and is unchanged after a paired issue.
REQ-024 In EXEC, one cycle after issue, SHALL capture the responses from dp_result and go to RESP.
REQ-025 Paired capture: A gets dp_result[2N-1:N] and B gets dp_result[N-1:0], each zero-extended to 2N bits.
REQ-026 Single capture: narrow ops SHALL take dp_result[N-1:0]; wide ops take the full 2N bits.
REQ-027 A divide with a zero divisor (lane divisor for narrow ops, full y for wide ops) SHALL return all-ones in that lane's result width, ignoring dp_result for that lane.
REQ-028 In RESP, each issued requester's rsp_valid SHALL stay high with stable data until its rsp_ready is sampled high; rsp_ready of a non-issued requester is ignored.
REQ-029 SHALL return to IDLE in the cycle after the last outstanding response is consumed; a new accept can occur in the following IDLE cycle.
REQ-030 Minimum latency SHALL be issue (cycle 0) -> rsp_valid at cycle 2, with 3 cycles per transaction when rsp_ready is held high.
REQ-031 a_ready and b_ready SHALL be 0 outside IDLE; requests that arrive during EXEC or RESP wait.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, all ready and rsp_valid outputs to 0, all dp_* outputs and response data to 0, and the pointer to A.
REQ-033 A reset during EXEC or RESP SHALL discard the transaction and produce no response after release.

Configuration
REQ-034 With macro SIMDIVE_PAIRING_EN defined, pairing SHALL follow REQ-020/021.
REQ-035 Without SIMDIVE_PAIRING_EN, SHALL never pair: dp_mode stays 0 and both-valid cases always use round-robin single issue.

Verification
REQ-036 A narrow mul x=0x0B, y=0x33 alone -> dp_mode=0, dp_func=000, a_rsp_valid at cycle 2, a_rsp_data = dp_result[15:0] zero-extended.
REQ-037 Both narrow, A mul 0x33*0x0B, B div 0x33/0x0B (macro on) -> dp_mode=1, dp_input1=0x3333, dp_input2=0x0B0B, dp_func=001, both responses in one transaction.
REQ-038 A wide and B narrow both valid, held for 2 transactions -> A served first, then B; pointer returns to A.
REQ-039 B div y=0 narrow -> b_rsp_data=0x0000FFFF, independent of dp_result.
REQ-040 Paired issue, a_rsp_ready=0 for 5 cycles while b_rsp_ready=1 -> B completes at once, a_rsp_valid holds with stable data, IDLE one cycle after A is consumed.
REQ-041 rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no response after release; with the macro off, the REQ-037 stimulus -> two single issues with dp_mode=0.
